// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
//
// Sequential execute-stage ALU. A 4-bit operation code from the ALU controller
// selects the operation on two operands. Single-cycle operations are written
// to the registered result at the same edge that accepts the request. Multiply
// runs as an iterative shift-add over WIDTH cycles, and busy_o tells the CPU
// control to stall while it is in progress.
//
// Handshake: a request is the pair (start_i, ALUCtrl_i/src1_i/src2_i) sampled
// at a rising edge. It is accepted only when busy_o is 0. A request presented
// while busy_o is 1 is dropped, not queued. Every accepted request produces
// exactly one done_o pulse, one cycle wide. result_o and zero_o are valid
// while done_o is high and hold their values until the next completion.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous, active-high reset
//   start_i      request strobe
//   ALUCtrl_i    operation code, sampled with start_i
//   src1_i       operand A, sampled with start_i
//   src2_i       operand B, sampled with start_i
//   result_o     registered result, held until the next completion
//   zero_o       registered (result_o == 0), updated together with result_o
//   busy_o       high while a multiply is in progress
//   done_o       one-cycle completion pulse
//   dbg_state_o  current FSM state (0 = IDLE, 1 = MUL), for observation only
// -----------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [0:0]       dbg_state_o
);

  // The counter must be able to hold the value WIDTH itself.
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_ADD2 = 4'b1010;
  localparam logic [3:0] OP_SUB2 = 4'b1110;
  localparam logic [3:0] OP_SLT2 = 4'b1111;

  logic [0:0]       state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] alu_res;
  logic             slt_bit;
  logic [WIDTH-1:0] acc_next;

  // ---------------------------------------------------------------------------
  // Single-cycle datapath. Operands come straight from the ports because they
  // are consumed at the accepting edge; nothing reaches an output without
  // passing through a register first.
  // ---------------------------------------------------------------------------
  assign slt_bit = ($signed(src1_i) < $signed(src2_i));

  always_comb begin
    alu_res = '0;
    case (ALUCtrl_i)
      OP_AND:           alu_res = src1_i & src2_i;
      OP_OR:            alu_res = src1_i | src2_i;
      OP_ADD, OP_ADD2:  alu_res = src1_i + src2_i;
      OP_SUB, OP_SUB2:  alu_res = src1_i - src2_i;
      OP_SLT, OP_SLT2:  alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
      default:          alu_res = '0;
    endcase
  end

  // One shift-add step: add the shifted multiplicand when the current
  // multiplier bit is set. Only the low WIDTH bits are kept, which gives the
  // same answer for signed and unsigned operands.
  assign acc_next = mplier[0] ? (acc + mcand) : acc;

  // ---------------------------------------------------------------------------
  // Control and state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      result_o <= '0;
      zero_o   <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      // done_o is a pulse; it is re-raised only by a completion below.
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            if (ALUCtrl_i == OP_MUL) begin
              mcand  <= src1_i;
              mplier <= src2_i;
              acc    <= '0;
              cnt    <= CNT_W'(WIDTH);
              state  <= ST_MUL;
            end else begin
              result_o <= alu_res;
              zero_o   <= (alu_res == '0);
              done_o   <= 1'b1;
            end
          end
        end

        ST_MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CNT_W'(1);
          // Last step: the counter goes 1 -> 0 on this edge, so the final
          // bit's contribution is taken from acc_next, not from acc.
          if (cnt == CNT_W'(1)) begin
            result_o <= acc_next;
            zero_o   <= (acc_next == '0);
            done_o   <= 1'b1;
            state    <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  // busy_o is decoded from the state register only, so it is glitch-free
  // with respect to the inputs.
  assign busy_o      = (state == ST_MUL);
  assign dbg_state_o = state;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq
//
// Directed test of alu_seq (WIDTH = 32). Inputs are driven on the falling
// edge; outputs are sampled 1 ns after the rising edge. Expected values are
// hand-computed constants held in an expected-result queue.
// -----------------------------------------------------------------------------
module tb_alu_seq;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   op = 4'b0000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] result;
  logic         zero;
  logic         busy;
  logic         done;
  logic [0:0]   dbg_state;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .ALUCtrl_i   (op),
    .src1_i      (a),
    .src2_i      (b),
    .result_o    (result),
    .zero_o      (zero),
    .busy_o      (busy),
    .done_o      (done),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
  endtask

  // Compare the completed result and zero flag against the oldest expectation.
  task automatic check_result(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_result"}, result, e);
      check({tag, "_zero"}, 32'(zero), 32'(e == '0));
    end
  endtask

  // ---------------- driver tasks ----------------
  // Single-cycle op: drive on the falling edge, result valid after the next
  // rising edge, done_o gone one edge later.
  task automatic do_alu(input string tag, input logic [3:0] o,
                        input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] exp);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check_result(tag);
    @(posedge clk); #1;
    check({tag, "_done_drop"}, 32'(done), 32'd0);
  endtask

  // Multiply: counts busy cycles and done pulses. Returns 1 ns after the
  // completion edge, i.e. still inside the done_o cycle. With poke set, a
  // second request is presented mid-multiply and must be dropped.
  task automatic do_mul(input string tag, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] exp,
                        input bit poke);
    int cycles;
    int dones;
    logic [W-1:0] prev_res;
    prev_res = result;
    cycles = 0;
    dones  = 0;
    @(negedge clk);
    start = 1'b1; op = 4'b0011; a = x; b = y;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    while (busy && cycles < 100) begin
      if (poke && cycles == 5) begin
        start = 1'b1; op = 4'b0010; a = 32'd7; b = 32'd9;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cycles++;
      if (done) dones++;
      if (cycles == 8) check({tag, "_held"}, result, prev_res);
    end
    start = 1'b0;
    check({tag, "_busy_cycles"}, 32'(cycles), 32'd32);
    check({tag, "_done_count"}, 32'(dones), 32'd1);
    check({tag, "_done_now"}, 32'(done), 32'd1);
    check_result(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int late_dones;

    // reset state
    #12;
    check("rst_result", result, 32'h0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // ADD wrap-around gives zero
    do_alu("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'h1, 32'h0);

    // opcode sweep with A = 0x80000000, B = 1
    do_alu("and",  4'b0000, 32'h8000_0000, 32'h1, 32'h0);
    do_alu("or",   4'b0001, 32'h8000_0000, 32'h1, 32'h8000_0001);
    do_alu("op5",  4'b0101, 32'h8000_0000, 32'h1, 32'h0);
    do_alu("sub",  4'b0110, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF);
    do_alu("slt",  4'b0111, 32'h8000_0000, 32'h1, 32'h1);
    do_alu("slt2", 4'b1111, 32'h8000_0000, 32'h1, 32'h1);
    do_alu("slt_false", 4'b0111, 32'h1, 32'h8000_0000, 32'h0);
    do_alu("add2", 4'b1010, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678);
    do_alu("beq",  4'b1110, 32'h1234, 32'h1234, 32'h0);
    do_alu("sub2", 4'b1110, 32'h10, 32'h11, 32'hFFFF_FFFF);
    do_alu("op4",  4'b0100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);

    // multiply with an ignored mid-flight request
    do_mul("mul1", 32'h0001_0003, 32'h0000_0005, 32'h0005_000F, 1'b1);
    @(posedge clk); #1;
    check("mul1_no_extra_done", 32'(done), 32'd0);
    check("mul1_hold", result, 32'h0005_000F);
    check("mul1_idle", 32'(busy), 32'd0);

    // -1 * -1, then ADD back-to-back in the done cycle
    do_mul("mul2", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    do_alu("b2b_add", 4'b0010, 32'd2, 32'd3, 32'd5);

    // reset ten cycles into a multiply
    @(negedge clk);
    start = 1'b1; op = 4'b0011; a = 32'h0001_0003; b = 32'h5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", result, 32'h0);
    check("abort_zero", 32'(zero), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    late_dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) late_dones++;
    end
    check("abort_no_done", 32'(late_dones), 32'd0);
    check("abort_idle", 32'(busy), 32'd0);

    do_alu("and_after_rst", 4'b0000, 32'hF0, 32'h3C, 32'h30);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard stop in case something wedges the stimulus thread.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $finish;
  end

endmodule
